bpu: RTL and testbench
======================

BPU -- requirements
Module: bpu

Interface
REQ-001 Parameter ENTRIES, default 16, number of BHT/BTB entries; power of two, 4..64.
REQ-002 clk_i  input  1  clock; all state updates on rising edge.
REQ-003 n_rst_i  input  1  reset, asynchronous, active-low.
REQ-004 pc_i  input  32  current fetch pc (ifu pc_o); lookup key.
REQ-005 next_pc_o  output  32  predicted next fetch pc, to ifu next_pc_i.
REQ-006 next_taken_o  output  1  predicted-taken flag, to ifu next_taken_i.
REQ-007 upd_valid_i  input  1  exu resolved a conditional branch/jump this cycle.
REQ-008 upd_pc_i  input  32  pc of the resolved instruction.
REQ-009 upd_taken_i  input  1  resolved direction, 1 = taken.
REQ-010 upd_target_i  input  32  resolved taken target.

Function
REQ-011 IDX_W = log2(ENTRIES); index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2].
REQ-012 State: BHT of ENTRIES 2-bit saturating counters, BTB of ENTRIES {valid, tag, target[31:2]}, 8-bit GHR (GHR only with macro, REQ-024).
REQ-013 Lookup combinational, zero latency: hit = btb_valid[idx] and btb_tag[idx] == tag(pc_i).
REQ-014 next_taken_o = hit and bht[idx][1]; next_pc_o = {btb_target[idx], 2'b00} when next_taken_o, else pc_i + 4.
REQ-015 pc_i + 4 wraps modulo 2^32 (0xFFFFFFFC -> 0x00000000).
REQ-016 On upd_valid_i: counter at update index increments if upd_taken_i (saturate at 2'b11), decrements otherwise (saturate at 2'b00).
REQ-017 On upd_valid_i and upd_taken_i: BTB entry written: valid = 1, tag = tag(upd_pc_i), target = upd_target_i[31:2]; overwrites any alias.
REQ-018 On upd_valid_i and not upd_taken_i: BTB untouched.
REQ-019 Update and lookup to same entry in same cycle: lookup sees pre-update contents (no bypass); new value visible next cycle.
REQ-020 upd_valid_i low: no state changes.

Reset
REQ-021 n_rst_i low asynchronously clears all BTB valid bits, sets every counter to 2'b01 (weakly not-taken), clears GHR.
REQ-022 During and immediately after reset: next_taken_o = 0, next_pc_o = pc_i + 4; update in a reset cycle discarded.
REQ-023 Reset mid-operation discards all learned history; no partial-state retention.

Configuration
REQ-024 Macro BPU_GSHARE_EN defined: BHT index (lookup and update) = pc index XOR GHR[IDX_W-1:0] (GHR zero-extended when IDX_W > 8); GHR shifts left by one, inserting upd_taken_i at bit 0, on each upd_valid_i; BTB index stays pc-only.
REQ-025 BPU_GSHARE_EN undefined: no GHR register; BHT indexed by pc index only.
REQ-026 Lookup and update both use current GHR value; GHR checkpointing out of scope.

Structure
REQ-027 defines.v holds BPU_ENTRIES default, BPU_GHR_W (8), counter encodings (SNT 00, WNT 01, WT 10, ST 11), INS_BUS_A width.
REQ-028 One sub-module, bpu_btb (valid/tag/target arrays, read port, write port); bpu keeps BHT, GHR, next-pc mux.

Verification
REQ-029 After reset, pc_i = 0x00000100 -> next_taken_o = 0, next_pc_o = 0x00000104.
REQ-030 One update {pc 0x100, taken, target 0x200}, then pc_i = 0x100 -> counter 10, next_taken_o = 1, next_pc_o = 0x00000200.
REQ-031 Four not-taken updates at pc 0x100 after REQ-030 -> counter 00, next_taken_o = 0, next_pc_o = 0x104; a fifth leaves counter at 00.
REQ-032 Alias (ENTRIES = 16): train pc 0x100 taken to 0x200, then lookup pc 0x500 (same index, different tag) -> next_taken_o = 0, next_pc_o = 0x504.
REQ-033 Same-cycle update {0x100, taken, 0x300} and lookup pc_i = 0x100 on a trained entry -> old target 0x200 this cycle, 0x300 next cycle.
REQ-034 pc_i = 0xFFFFFFFC, untrained -> next_pc_o = 0x00000000; assert n_rst_i mid-run -> all predictions revert to REQ-029 behaviour without a clock edge.

Source files
------------

// File: rtl/bpu_pkg.sv
// Shared BPU constants, 2-bit counter encodings and the saturating update helper.
// Build option: define BPU_GSHARE_EN to XOR the global history into the BHT index.
package bpu_pkg;

    localparam int BPU_ENTRIES = 16;
    localparam int BPU_GHR_W   = 8;
    localparam int INS_BUS_A   = 32;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    // Counters stick at SNT/ST instead of wrapping.
    function automatic ctr_t ctr_next(input ctr_t cur, input logic taken);
        ctr_t nxt;
        nxt = cur;
        if (taken) begin
            if (cur != ST) nxt = ctr_t'(cur + 2'd1);
        end else begin
            if (cur != SNT) nxt = ctr_t'(cur - 2'd1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bpu_btb.sv
// Direct-mapped branch target buffer: combinational read port, clocked write port.
// Only the valid bits are reset; tags and targets are don't-care until valid is set.
module bpu_btb
    import bpu_pkg::*;
#(
    parameter int ENTRIES = BPU_ENTRIES,
    parameter int TAG_W   = INS_BUS_A - $clog2(BPU_ENTRIES) - 2
) (
    input  logic                       clk_i,
    input  logic                       n_rst_i,
    input  logic [$clog2(ENTRIES)-1:0] rd_idx_i,
    input  logic [TAG_W-1:0]           rd_tag_i,
    output logic                       hit_o,
    output logic [INS_BUS_A-3:0]       rd_target_o,
    input  logic                       wr_en_i,
    input  logic [$clog2(ENTRIES)-1:0] wr_idx_i,
    input  logic [TAG_W-1:0]           wr_tag_i,
    input  logic [INS_BUS_A-3:0]       wr_target_i
);

    logic [ENTRIES-1:0]   valid;
    logic [TAG_W-1:0]     tags    [ENTRIES];
    logic [INS_BUS_A-3:0] targets [ENTRIES];

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            valid <= '0;
        end else if (wr_en_i) begin
            valid[wr_idx_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            tags[wr_idx_i]    <= wr_tag_i;
            targets[wr_idx_i] <= wr_target_i;
        end
    end

    assign hit_o       = valid[rd_idx_i] && (tags[rd_idx_i] == rd_tag_i);
    assign rd_target_o = targets[rd_idx_i];

endmodule

// File: rtl/bpu.sv
// Branch prediction unit: bimodal (or gshare with BPU_GSHARE_EN) BHT plus BTB,
// zero-latency lookup on pc_i, training from the execute-stage resolution port.
module bpu
    import bpu_pkg::*;
#(
    parameter int ENTRIES = BPU_ENTRIES
) (
    input  logic                 clk_i,
    input  logic                 n_rst_i,
    input  logic [INS_BUS_A-1:0] pc_i,
    output logic [INS_BUS_A-1:0] next_pc_o,
    output logic                 next_taken_o,
    input  logic                 upd_valid_i,
    input  logic [INS_BUS_A-1:0] upd_pc_i,
    input  logic                 upd_taken_i,
    input  logic [INS_BUS_A-1:0] upd_target_i
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = INS_BUS_A - IDX_W - 2;

    logic [IDX_W-1:0]     pc_idx;
    logic [IDX_W-1:0]     upd_idx;
    logic [IDX_W-1:0]     bht_rd_idx;
    logic [IDX_W-1:0]     bht_wr_idx;
    logic [TAG_W-1:0]     pc_tag;
    logic [TAG_W-1:0]     upd_tag;
    logic                 btb_hit;
    logic [INS_BUS_A-3:0] btb_target;
    ctr_t                 rd_ctr;
    ctr_t                 bht [ENTRIES];
    logic                 unused_bits;

    assign pc_idx  = pc_i[IDX_W+1:2];
    assign pc_tag  = pc_i[INS_BUS_A-1:IDX_W+2];
    assign upd_idx = upd_pc_i[IDX_W+1:2];
    assign upd_tag = upd_pc_i[INS_BUS_A-1:IDX_W+2];

    assign unused_bits = ^{upd_pc_i[1:0], upd_target_i[1:0]};

`ifdef BPU_GSHARE_EN
    logic [BPU_GHR_W-1:0] ghr;
    logic [IDX_W-1:0]     ghr_idx;

    if (IDX_W > BPU_GHR_W) begin : g_ghr_ext
        assign ghr_idx = {{(IDX_W-BPU_GHR_W){1'b0}}, ghr};
    end else begin : g_ghr_cut
        assign ghr_idx = ghr[IDX_W-1:0];
    end

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            ghr <= '0;
        end else if (upd_valid_i) begin
            ghr <= {ghr[BPU_GHR_W-2:0], upd_taken_i};
        end
    end

    // Both ports hash with the current history; no speculative checkpointing.
    assign bht_rd_idx = pc_idx ^ ghr_idx;
    assign bht_wr_idx = upd_idx ^ ghr_idx;
`else
    assign bht_rd_idx = pc_idx;
    assign bht_wr_idx = upd_idx;
`endif

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                bht[i] <= WNT;
            end
        end else if (upd_valid_i) begin
            bht[bht_wr_idx] <= ctr_next(bht[bht_wr_idx], upd_taken_i);
        end
    end

    bpu_btb #(
        .ENTRIES (ENTRIES),
        .TAG_W   (TAG_W)
    ) u_btb (
        .clk_i       (clk_i),
        .n_rst_i     (n_rst_i),
        .rd_idx_i    (pc_idx),
        .rd_tag_i    (pc_tag),
        .hit_o       (btb_hit),
        .rd_target_o (btb_target),
        .wr_en_i     (upd_valid_i && upd_taken_i),
        .wr_idx_i    (upd_idx),
        .wr_tag_i    (upd_tag),
        .wr_target_i (upd_target_i[INS_BUS_A-1:2])
    );

    // Lookup reads pre-update state; a same-cycle update shows up next cycle.
    assign rd_ctr       = bht[bht_rd_idx];
    assign next_taken_o = btb_hit && ((rd_ctr == WT) || (rd_ctr == ST));
    assign next_pc_o    = next_taken_o ? {btb_target, 2'b00} : pc_i + 32'd4;

endmodule

// File: tb/tb_bpu.sv
// Self-checking bench for bpu (ENTRIES = 16): reference model feeds an expected-value
// queue that a negedge monitor drains against the DUT outputs.
module tb_bpu;

    logic        clk_i = 1'b0;
    logic        n_rst_i;
    logic [31:0] pc_i;
    logic [31:0] next_pc_o;
    logic        next_taken_o;
    logic        upd_valid_i;
    logic [31:0] upd_pc_i;
    logic        upd_taken_i;
    logic [31:0] upd_target_i;

    int checks = 0;
    int passes = 0;

    typedef struct {
        string       tag;
        logic        taken;
        logic [31:0] npc;
    } exp_t;

    exp_t exp_q[$];

    int unsigned m_ctr [16];
    bit          m_val [16];
    logic [25:0] m_tag [16];
    logic [29:0] m_tgt [16];
    logic [7:0]  m_ghr;

    bpu #(.ENTRIES(16)) dut (
        .clk_i        (clk_i),
        .n_rst_i      (n_rst_i),
        .pc_i         (pc_i),
        .next_pc_o    (next_pc_o),
        .next_taken_o (next_taken_o),
        .upd_valid_i  (upd_valid_i),
        .upd_pc_i     (upd_pc_i),
        .upd_taken_i  (upd_taken_i),
        .upd_target_i (upd_target_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [32:0] actual, input logic [32:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    endtask

    function automatic logic [3:0] bhtIdx(input logic [31:0] pc);
        logic [3:0] idx;
        idx = pc[5:2];
`ifdef BPU_GSHARE_EN
        idx = idx ^ m_ghr[3:0];
`endif
        return idx;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 16; i++) begin
            m_ctr[i] = 1;
            m_val[i] = 1'b0;
            m_tag[i] = '0;
            m_tgt[i] = '0;
        end
        m_ghr = '0;
    endtask

    task automatic modelUpdate(input logic [31:0] upc, input logic ut, input logic [31:0] utgt);
        logic [3:0] b;
        logic [3:0] e;
        b = bhtIdx(upc);
        e = upc[5:2];
        if (ut && m_ctr[b] < 3) m_ctr[b]++;
        if (!ut && m_ctr[b] > 0) m_ctr[b]--;
        if (ut) begin
            m_val[e] = 1'b1;
            m_tag[e] = upc[31:6];
            m_tgt[e] = utgt[31:2];
        end
        m_ghr = {m_ghr[6:0], ut};
    endtask

    task automatic applyStimulus(input string tag, input logic [31:0] pc, input logic uv,
                                 input logic [31:0] upc, input logic ut, input logic [31:0] utgt);
        exp_t e;
        logic hit;
        @(posedge clk_i);
        #1;
        pc_i         = pc;
        upd_valid_i  = uv;
        upd_pc_i     = upc;
        upd_taken_i  = ut;
        upd_target_i = utgt;
        hit     = m_val[pc[5:2]] && (m_tag[pc[5:2]] == pc[31:6]);
        e.tag   = tag;
        e.taken = hit && (m_ctr[bhtIdx(pc)] >= 2);
        e.npc   = e.taken ? {m_tgt[pc[5:2]], 2'b00} : pc + 32'd4;
        exp_q.push_back(e);
        if (uv) modelUpdate(upc, ut, utgt);
        @(negedge clk_i);
        #1;
    endtask

    always @(negedge clk_i) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checkOutput(e.tag, {next_taken_o, next_pc_o}, {e.taken, e.npc});
        end
    end

    initial begin
        logic [31:0] pool [8];
        pool = '{32'h100, 32'h500, 32'h140, 32'h180, 32'h1C0, 32'h900, 32'h104, 32'hFFFFFFFC};

        n_rst_i      = 1'b0;
        pc_i         = 32'h0;
        upd_valid_i  = 1'b0;
        upd_pc_i     = 32'h0;
        upd_taken_i  = 1'b0;
        upd_target_i = 32'h0;
        modelReset();
        repeat (3) @(posedge clk_i);
        #1;
        checkOutput("reset_state", {next_taken_o, next_pc_o}, {1'b0, 32'h4});
        @(negedge clk_i);
        n_rst_i = 1'b1;

        applyStimulus("cold_lookup",   32'h100, 1'b0, 32'h0,   1'b0, 32'h0);
        applyStimulus("train_taken",   32'h0,   1'b1, 32'h100, 1'b1, 32'h200);
        applyStimulus("trained_hit",   32'h100, 1'b0, 32'h0,   1'b0, 32'h0);
        applyStimulus("alias_miss",    32'h500, 1'b0, 32'h0,   1'b0, 32'h0);
        applyStimulus("same_cyc_old",  32'h100, 1'b1, 32'h100, 1'b1, 32'h300);
        applyStimulus("same_cyc_new",  32'h100, 1'b0, 32'h0,   1'b0, 32'h0);
        for (int i = 0; i < 5; i++)
            applyStimulus("not_taken_seq", 32'h100, 1'b1, 32'h100, 1'b0, 32'h0);
        applyStimulus("sat_low",       32'h100, 1'b1, 32'h100, 1'b1, 32'h200);
        applyStimulus("one_up_weak",   32'h100, 1'b0, 32'h0,   1'b0, 32'h0);
        applyStimulus("wrap_pc",       32'hFFFFFFFC, 1'b0, 32'h0, 1'b0, 32'h0);

        for (int i = 0; i < 150; i++)
            applyStimulus("random", pool[$urandom_range(0, 7)], 1'($urandom_range(0, 1)),
                          pool[$urandom_range(0, 7)], 1'($urandom_range(0, 1)), $urandom());

        applyStimulus("retrain_a", 32'h0,   1'b1, 32'h100, 1'b1, 32'h200);
        applyStimulus("retrain_b", 32'h0,   1'b1, 32'h100, 1'b1, 32'h200);
        applyStimulus("pre_reset", 32'h100, 1'b0, 32'h0,   1'b0, 32'h0);

        // Asynchronous reset between clock edges, with an update held during reset.
        #1;
        n_rst_i = 1'b0;
        modelReset();
        #1;
        checkOutput("async_reset", {next_taken_o, next_pc_o}, {1'b0, 32'h104});
        upd_valid_i  = 1'b1;
        upd_pc_i     = 32'h100;
        upd_taken_i  = 1'b1;
        upd_target_i = 32'h600;
        @(posedge clk_i);
        #1;
        checkOutput("reset_upd_drop", {next_taken_o, next_pc_o}, {1'b0, 32'h104});
        @(negedge clk_i);
        upd_valid_i = 1'b0;
        n_rst_i     = 1'b1;

        applyStimulus("post_reset",  32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
        applyStimulus("post_reset2", 32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
        repeat (2) @(negedge clk_i);
        checkOutput("queue_drained", 33'(exp_q.size()), 33'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
